// File: rtl/digit_entry.sv
// Two-digit BCD entry stage: synchronizes and debounces the enter/clear buttons
// and shifts switch digits into a rolling two-digit register. Optional digit check: DIGIT_ENTRY_BCD_CHECK_EN.
module digit_entry #(
    parameter int DB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw_digit,
    input  logic       key_n,
    input  logic       clr_n,
    output logic [7:0] digits,
    output logic [1:0] count,
    output logic       full,
    output logic       err
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
    localparam int ENTER = 0;
    localparam int CLEAR = 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    sw_meta, sw_sync;
    logic [1:0]    btn_meta, btn_sync, btn_db, btn_db_d;
    logic [CW-1:0] btn_cnt [2];
    logic          enter_evt, clr_evt, digit_ok;

    // NOTE: every flop uses non-blocking assignments so all stages sample pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta  <= 4'h0;
            sw_sync  <= 4'h0;
            btn_meta <= 2'b11;
            btn_sync <= 2'b11;
            btn_db   <= 2'b11;
            btn_db_d <= 2'b11;
            for (int i = 0; i < 2; i++) btn_cnt[i] <= '0;
        end else begin
            sw_meta  <= sw_digit;
            sw_sync  <= sw_meta;
            btn_meta <= {clr_n, key_n};
            btn_sync <= btn_meta;
            btn_db_d <= btn_db;
            for (int i = 0; i < 2; i++) begin
                if (btn_sync[i] == btn_db[i]) begin
                    btn_cnt[i] <= '0;
                end else if (btn_cnt[i] == CNT_MAX) begin
                    // Level held long enough: accept it and restart the count.
                    btn_db[i]  <= btn_sync[i];
                    btn_cnt[i] <= '0;
                end else begin
                    btn_cnt[i] <= btn_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press is a one-cycle high-to-low step of the debounced level; release is ignored.
    assign enter_evt = btn_db_d[ENTER] & ~btn_db[ENTER];
    assign clr_evt   = btn_db_d[CLEAR] & ~btn_db[CLEAR];

`ifdef DIGIT_ENTRY_BCD_CHECK_EN
    assign digit_ok = (sw_sync <= 4'd9);
`else
    assign digit_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            digits <= 8'h00;
            full   <= 1'b0;
            err    <= 1'b0;
        end else begin
            err <= 1'b0;
            if (clr_evt) begin
                // Clear wins over a simultaneous enter; that digit is dropped silently.
                state  <= EMPTY;
                digits <= 8'h00;
                full   <= 1'b0;
            end else if (enter_evt) begin
                if (digit_ok) begin
                    digits <= {digits[3:0], sw_sync};
                    case (state)
                        EMPTY: begin
                            state <= ONE;
                            full  <= 1'b0;
                        end
                        default: begin
                            state <= FULL;
                            full  <= 1'b1;
                        end
                    endcase
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign count = state;

endmodule

// File: tb/tb_digit_entry.sv
// Directed bench for digit_entry with DB_CYCLES=4; expectations follow the build's digit-check setting.
module tb_digit_entry;

    localparam int DB = 4;
`ifdef DIGIT_ENTRY_BCD_CHECK_EN
    localparam bit BCD = 1'b1;
`else
    localparam bit BCD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sw_digit = 4'h0;
    logic       key_n = 1'b1;
    logic       clr_n = 1'b1;
    logic [7:0] digits;
    logic [1:0] count;
    logic       full;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_digits = 8'h00;
    logic [1:0] exp_count  = 2'd0;

    digit_entry #(.DB_CYCLES(DB)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_digit (sw_digit),
        .key_n    (key_n),
        .clr_n    (clr_n),
        .digits   (digits),
        .count    (count),
        .full     (full),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Each tick ends at the falling edge following one rising edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_state(input string name, input logic [7:0] d, input logic [1:0] c,
                                input logic e);
        n_checks++;
        if ({digits, count, full, err} !== {d, c, (c == 2'd2), e}) begin
            n_fail++;
            $display("FAIL %s: got digits=%h count=%0d full=%b err=%b, want digits=%h count=%0d full=%b err=%b",
                     name, digits, count, full, err, d, c, (c == 2'd2), e);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(2);
        expect_state("reset_values", 8'h00, 2'd0, 1'b0);
        reset = 1'b0;
        tick(2);
        expect_state("after_reset_idle", 8'h00, 2'd0, 1'b0);
    endtask

    // Press with digit d and check the exact update edge, the err pulse width and no repeat on hold.
    task automatic enter_digit(input logic [3:0] d, input string name);
        logic [7:0] pre_d;
        logic [1:0] pre_c;
        logic       bad;
        pre_d = exp_digits;
        pre_c = exp_count;
        bad   = BCD && (d > 4'd9);
        if (!bad) begin
            exp_digits = {exp_digits[3:0], d};
            exp_count  = (exp_count == 2'd2) ? 2'd2 : exp_count + 2'd1;
        end
        sw_digit = d;
        tick(3);
        key_n = 1'b0;
        tick(6);
        expect_state({name, "_before"}, pre_d, pre_c, 1'b0);
        tick(1);
        expect_state({name, "_update"}, exp_digits, exp_count, bad);
        tick(1);
        expect_state({name, "_err_end"}, exp_digits, exp_count, 1'b0);
        tick(10);
        expect_state({name, "_held"}, exp_digits, exp_count, 1'b0);
        key_n = 1'b1;
        tick(DB + 6);
        expect_state({name, "_released"}, exp_digits, exp_count, 1'b0);
    endtask

    task automatic test_basic_entry;
        enter_digit(4'd8, "enter_8");
        enter_digit(4'd4, "enter_4");
    endtask

    task automatic test_glitch;
        sw_digit = 4'd5;
        tick(3);
        key_n = 1'b0;
        tick(3);
        key_n = 1'b1;
        tick(12);
        expect_state("glitch_3cyc", exp_digits, exp_count, 1'b0);
    endtask

    task automatic test_invalid_digit;
        enter_digit(4'hA, "invalid_A");
    endtask

    task automatic test_rolling_and_clear;
        enter_digit(4'd3, "rolling_3");
        sw_digit = 4'd7;
        tick(3);
        key_n = 1'b0;
        clr_n = 1'b0;
        tick(6);
        expect_state("clr_enter_before", exp_digits, exp_count, 1'b0);
        exp_digits = 8'h00;
        exp_count  = 2'd0;
        tick(1);
        expect_state("clr_enter_same_cycle", 8'h00, 2'd0, 1'b0);
        tick(1);
        expect_state("clr_enter_after", 8'h00, 2'd0, 1'b0);
        key_n = 1'b1;
        clr_n = 1'b1;
        tick(DB + 6);
        expect_state("clr_released", 8'h00, 2'd0, 1'b0);
    endtask

    task automatic test_reset_mid_debounce;
        enter_digit(4'd2, "pre_reset_2");
        sw_digit = 4'd6;
        tick(3);
        key_n = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(2);
        expect_state("reset_mid_debounce", 8'h00, 2'd0, 1'b0);
        reset = 1'b0;
        tick(6);
        expect_state("post_reset_no_event", 8'h00, 2'd0, 1'b0);
        tick(1);
        expect_state("post_reset_event", 8'h06, 2'd1, 1'b0);
        tick(10);
        expect_state("post_reset_held", 8'h06, 2'd1, 1'b0);
        key_n = 1'b1;
        tick(DB + 6);
        exp_digits = 8'h06;
        exp_count  = 2'd1;
    endtask

    task automatic test_back_to_back;
        enter_digit(4'd9, "b2b_9");
        enter_digit(4'd0, "b2b_0");
        enter_digit(4'd1, "b2b_1");
    endtask

    initial begin
        tick(1);
        test_reset;
        test_basic_entry;
        test_glitch;
        test_invalid_digit;
        test_rolling_and_clear;
        test_reset_mid_debounce;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
